// File: rtl/relax_commit_unit_pkg.sv
// relax_commit_unit_pkg: shared constants, relaxation word layout and FSM
// state type for the Bellman-Ford relaxation commit unit.
package relax_commit_unit_pkg;

    localparam int unsigned N_NODES = 32;  // distance array depth
    localparam int unsigned IDX_W   = 5;   // vertex index width
    localparam int unsigned DIST_W  = 7;   // distance width
    localparam int unsigned EW_W    = 4;   // edge weight width
    localparam int unsigned LANES   = 4;   // words per batch
    localparam int unsigned LANE_W  = 2;   // lane counter width
    localparam int unsigned WORD_W  = 22;  // relaxation word width
    localparam int unsigned CNT_W   = 8;   // improvement counter width

    localparam logic [DIST_W-1:0] DIST_INF = '1;

    // Word layout, MSB first:
    // [21] valid, [20:17] W[i,j], [16:12] i, [11:7] j, [6:0] W[i]
    typedef struct packed {
        logic              valid;
        logic [EW_W-1:0]   w;
        logic [IDX_W-1:0]  i;
        logic [IDX_W-1:0]  j;
        logic [DIST_W-1:0] wi;
    } relax_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/relax_commit_unit_calc.sv
// relax_calc: combinational evaluation of one relaxation word against the
// current distance of its destination.
//   word_i      relaxation word (valid, W[i,j], i, j, W[i])
//   cur_dist_i  current dist[j]
//   active_o    word is valid and W[i] is finite
//   cand_o      W[i,j] + W[i], saturated to DIST_INF
//   improve_o   active and cand strictly below cur_dist
module relax_calc
    import relax_commit_unit_pkg::*;
(
    input  relax_word_t        word_i,
    input  logic [DIST_W-1:0]  cur_dist_i,
    output logic               active_o,
    output logic [DIST_W-1:0]  cand_o,
    output logic               improve_o
);

    logic [DIST_W:0] sum;
    // The source index does not influence the decision.
    logic            unused_src_idx;

    assign unused_src_idx = ^word_i.i;

    always_comb begin
        sum       = {1'b0, word_i.wi} + (DIST_W + 1)'(word_i.w);
        active_o  = word_i.valid && (word_i.wi != DIST_INF);
        cand_o    = sum[DIST_W] ? DIST_INF : sum[DIST_W-1:0];
        improve_o = active_o && (cand_o < cur_dist_i);
    end

endmodule

// File: rtl/relax_commit_unit.sv
// relax_commit_unit: accepts batches of four sorted relaxation words and
// commits improving candidate distances, one lane per cycle, into an
// internal distance array. Tracks a sticky change flag and a saturating
// improvement count for convergence detection.
//   clk, rst_n            clock, async active-low reset
//   init, src             start distance initialisation from source src
//   in_valid, in_ready    batch handshake
//   A_new..D_new          lane 0..3 words
//   round_clr             clear the change flag
//   changed, upd_count    convergence status
//   busy                  FSM not idle
//   q_idx, q_dist         registered distance query
module relax_commit_unit
    import relax_commit_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic [IDX_W-1:0]   src,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  A_new,
    input  logic [WORD_W-1:0]  B_new,
    input  logic [WORD_W-1:0]  C_new,
    input  logic [WORD_W-1:0]  D_new,
    input  logic               round_clr,
    output logic               changed,
    output logic [CNT_W-1:0]   upd_count,
    output logic               busy,
    input  logic [IDX_W-1:0]   q_idx,
    output logic [DIST_W-1:0]  q_dist
);

    localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(N_NODES - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    relax_word_t        batch_q [LANES];
    logic               batch_ld;
    logic               changed_q, changed_d;
    logic [CNT_W-1:0]   upd_q, upd_d;
    logic [DIST_W-1:0]  dist_q [N_NODES];
    logic [DIST_W-1:0]  q_dist_q;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [DIST_W-1:0]  wr_data;

    relax_word_t        cur_word;
    logic [DIST_W-1:0]  cur_dist;
    logic               lane_active;
    logic [DIST_W-1:0]  cand;
    logic               improve;
    logic               j_ok;

    assign cur_word = batch_q[lane_q];
    assign cur_dist = dist_q[cur_word.j];

    relax_calc u_calc (
        .word_i     (cur_word),
        .cur_dist_i (cur_dist),
        .active_o   (lane_active),
        .cand_o     (cand),
        .improve_o  (improve)
    );

    // Destinations beyond the array are ignored; with a full index range
    // every j is legal.
    if (N_NODES >= (1 << IDX_W)) begin : g_j_full
        assign j_ok = 1'b1;
    end else begin : g_j_part
        assign j_ok = (cur_word.j < IDX_W'(N_NODES));
    end

    assign in_ready  = (state_q == ST_IDLE) && !init;
    assign busy      = (state_q != ST_IDLE);
    assign changed   = changed_q;
    assign upd_count = upd_q;
    assign q_dist    = q_dist_q;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        k_d       = k_q;
        lane_d    = lane_q;
        batch_ld  = 1'b0;
        changed_d = changed_q;
        upd_d     = upd_q;
        wr_en     = 1'b0;
        wr_idx    = k_q;
        wr_data   = DIST_INF;

        // An improvement later in this block overrides the clear.
        if (round_clr) begin
            changed_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    batch_ld = 1'b1;
                    lane_d   = '0;
                    state_d  = ST_COMMIT;
                end
            end
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_idx  = k_q;
                wr_data = (k_q == src_q) ? '0 : DIST_INF;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (improve && j_ok) begin
                    wr_en     = 1'b1;
                    wr_idx    = cur_word.j;
                    wr_data   = cand;
                    changed_d = 1'b1;
                    if (upd_q != '1) begin
                        upd_d = upd_q + 1'b1;
                    end
                end
                lane_d = lane_q + 1'b1;
                if (lane_q == LANE_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // init aborts whatever is in flight, including the current lane write.
        if (init) begin
            state_d   = ST_INIT;
            src_d     = src;
            k_d       = '0;
            batch_ld  = 1'b0;
            wr_en     = 1'b0;
            changed_d = 1'b0;
            upd_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            k_q       <= '0;
            lane_q    <= '0;
            changed_q <= 1'b0;
            upd_q     <= '0;
            q_dist_q  <= DIST_INF;
            for (int unsigned l = 0; l < LANES; l++) begin
                batch_q[l] <= '0;
            end
            for (int unsigned n = 0; n < N_NODES; n++) begin
                dist_q[n] <= DIST_INF;
            end
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            k_q       <= k_d;
            lane_q    <= lane_d;
            changed_q <= changed_d;
            upd_q     <= upd_d;
            q_dist_q  <= dist_q[q_idx];
            if (batch_ld) begin
                batch_q[0] <= A_new;
                batch_q[1] <= B_new;
                batch_q[2] <= C_new;
                batch_q[3] <= D_new;
            end
            if (wr_en) begin
                dist_q[wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_relax_commit_unit.sv
module tb_relax_commit_unit;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        init      = 1'b0;
    logic [4:0]  src       = '0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [21:0] A_new     = '0;
    logic [21:0] B_new     = '0;
    logic [21:0] C_new     = '0;
    logic [21:0] D_new     = '0;
    logic        round_clr = 1'b0;
    logic        changed;
    logic [7:0]  upd_count;
    logic        busy;
    logic [4:0]  q_idx     = '0;
    logic [6:0]  q_dist;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_dist [32];
    int m_upd;
    bit m_changed;

    logic [21:0] wq   [4];
    logic [6:0]  qlog [5];

    relax_commit_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .src       (src),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_new     (A_new),
        .B_new     (B_new),
        .C_new     (C_new),
        .D_new     (D_new),
        .round_clr (round_clr),
        .changed   (changed),
        .upd_count (upd_count),
        .busy      (busy),
        .q_idx     (q_idx),
        .q_dist    (q_dist)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] mk(input bit v, input logic [3:0] w, input logic [4:0] i,
                                       input logic [4:0] j, input logic [6:0] wi);
        return {v, w, i, j, wi};
    endfunction

    task automatic model_reset(input int s);
        for (int n = 0; n < 32; n++) m_dist[n] = (n == s) ? 0 : 127;
        m_upd     = 0;
        m_changed = 0;
    endtask

    // One lane of relaxation at the level of the algorithm: candidate
    // distance, saturated, kept only if strictly shorter.
    task automatic model_lane(input logic [21:0] wd, input bit rc);
        int wi, w, j, cand;
        bit imp;
        wi  = int'(wd[6:0]);
        w   = int'(wd[20:17]);
        j   = int'(wd[11:7]);
        imp = 0;
        if (wd[21] && wi != 127) begin
            cand = wi + w;
            if (cand > 127) cand = 127;
            if (cand < m_dist[j]) begin
                m_dist[j] = cand;
                imp = 1;
            end
        end
        if (imp) begin
            m_changed = 1;
            if (m_upd < 255) m_upd++;
        end else if (rc) begin
            m_changed = 0;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_changed"}, 32'(changed), 32'(m_changed));
        chk({tag, "_upd"}, 32'(upd_count), 32'(m_upd));
    endtask

    task automatic dump(input string tag);
        for (int n = 0; n < 32; n++) begin
            q_idx = 5'(n);
            step();
            chk($sformatf("%s_q_dist[%0d]", tag, n), 32'(q_dist), 32'(m_dist[n]));
        end
    endtask

    // Pulses init (with a competing in_valid) and walks the 32-cycle sweep.
    task automatic do_init(input int s);
        init     = 1'b1;
        src      = 5'(s);
        in_valid = 1'b1;
        A_new    = 22'($urandom);
        B_new    = 22'($urandom);
        C_new    = 22'($urandom);
        D_new    = 22'($urandom);
        #1;
        chk("in_ready_with_init", 32'(in_ready), 32'd0);
        step();
        init     = 1'b0;
        in_valid = 1'b0;
        model_reset(s);
        for (int c = 0; c < 32; c++) begin
            chk("busy_during_init", 32'(busy), 32'd1);
            step();
        end
        chk("busy_after_init", 32'(busy), 32'd0);
        chk("in_ready_after_init", 32'(in_ready), 32'd1);
        check_status("init");
    endtask

    task automatic accept();
        chk("in_ready_before_batch", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        A_new    = wq[0];
        B_new    = wq[1];
        C_new    = wq[2];
        D_new    = wq[3];
        step();
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic finish(input logic [3:0] rc);
        for (int l = 0; l < 4; l++) begin
            qlog[l] = q_dist;
            chk("in_ready_low_commit", 32'(in_ready), 32'd0);
            round_clr = rc[l];
            model_lane(wq[l], rc[l]);
            step();
        end
        round_clr = 1'b0;
        qlog[4] = q_dist;
        chk("in_ready_after_commit", 32'(in_ready), 32'd1);
        chk("busy_after_commit", 32'(busy), 32'd0);
        check_status("commit");
    endtask

    task automatic rand_batch();
        int r;
        logic [6:0] wi;
        for (int l = 0; l < 4; l++) begin
            r  = $urandom_range(0, 7);
            wi = (r == 0) ? 7'h7F : (r == 1) ? 7'h7E : 7'($urandom_range(0, 40));
            wq[l] = mk(($urandom_range(0, 4) != 0), 4'($urandom), 5'($urandom),
                       5'($urandom_range(0, 7)), wi);
        end
        q_idx = 5'($urandom);
        accept();
        finish(4'($urandom) & 4'($urandom));
    endtask

    initial begin
        model_reset(-1);

        // Reset
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_q_dist", 32'(q_dist), 32'h7F);
        check_status("reset");
        dump("reset");

        // Initialisation from vertex 3
        do_init(3);
        dump("init3");

        // Single active lane: dist[7] = 4
        wq[0] = mk(1, 4, 3, 7, 0);
        wq[1] = mk(0, 1, 3, 8, 0);
        wq[2] = mk(0, 1, 3, 9, 0);
        wq[3] = mk(0, 1, 3, 10, 0);
        q_idx = 5'd7;
        accept();
        finish(4'b0000);
        chk("q7_same_cycle_write", 32'(qlog[1]), 32'h7F);
        chk("q7_after_lane0", 32'(qlog[2]), 32'd4);
        chk("single_changed", 32'(changed), 32'd1);
        chk("single_upd", 32'(upd_count), 32'd1);

        // Same-destination chain: 9 (no), 2 (yes), 3 (no), inactive 0
        wq[0] = mk(1, 4, 3, 7, 5);
        wq[1] = mk(1, 2, 3, 7, 0);
        wq[2] = mk(1, 2, 3, 7, 1);
        wq[3] = mk(0, 0, 3, 7, 0);
        accept();
        finish(4'b0000);
        chk("chain_dist7", 32'(qlog[4]), 32'd2);
        chk("chain_upd", 32'(upd_count), 32'd2);

        // round_clr while idle
        round_clr = 1'b1;
        step();
        round_clr = 1'b0;
        m_changed = 0;
        chk("round_clr_idle", 32'(changed), 32'd0);

        // Saturation, INF source, invalid lane, exact-127 sum
        wq[0] = mk(1, 4, 3, 9, 7'h7E);
        wq[1] = mk(1, 0, 3, 10, 7'h7F);
        wq[2] = mk(0, 1, 3, 11, 0);
        wq[3] = mk(1, 15, 3, 12, 7'h70);
        accept();
        finish(4'b0000);
        chk("sat_changed", 32'(changed), 32'd0);
        dump("sat");

        // Abort: init during lane 2 of a commit
        for (int l = 0; l < 4; l++) wq[l] = mk(1, 1, 0, 5'(20 + l), 0);
        accept();
        step();
        step();
        do_init(0);
        dump("abort");

        // Drive upd_count to saturation with strictly decreasing candidates
        for (int b = 0; b < 70; b++) begin
            int j, base;
            j    = 1 + (b % 31);
            base = m_dist[j];
            for (int l = 0; l < 4; l++) wq[l] = mk(1, 0, 0, 5'(j), 7'(base - 1 - l));
            accept();
            finish(4'(b));
        end
        chk("upd_saturated", 32'(upd_count), 32'd255);

        // Randomised batches against the model
        do_init($urandom_range(0, 31));
        for (int b = 0; b < 40; b++) rand_batch();
        dump("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
